// File: rtl/ball_mover.sv
// Ball position and frame sequencer: erase old 4x4 box, step the ball, redraw it,
// streaming pixels to the plotter over a valid/ready handshake once per frame tick.
module ball_mover #(
   parameter int       X_START   = 156,
   parameter int       Y_START   = 116,
   parameter int       BALL_SIZE = 4,
   parameter int       STEP      = 1,
   parameter int       X_MAX     = 320,
   parameter int       Y_MAX     = 240,
   parameter int       FRAME_DIV = 833334,
   parameter bit [2:0] BALL_COL  = 3'b111,
   parameter bit [2:0] BG_COL    = 3'b000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        horizontal,
   input  logic        vertical,
   input  logic        stop,
   output logic [10:0] x_ball,
   output logic [10:0] y_ball,
   output logic [10:0] plot_x,
   output logic [10:0] plot_y,
   output logic [2:0]  plot_colour,
   output logic        plot_valid,
   input  logic        plot_ready,
   output logic        col_enable,
   output logic        frame_done,
   output logic        halted
);

   localparam int          CNT_W    = $clog2(FRAME_DIV + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
   localparam logic [11:0] X_LIM    = 12'(X_MAX - BALL_SIZE);
   localparam logic [11:0] Y_LIM    = 12'(Y_MAX - BALL_SIZE);
   localparam logic [11:0] STEP_W   = 12'(STEP);

   typedef enum logic [2:0] {S_WAIT, S_ERASE, S_MOVE, S_DRAW, S_DONE, S_HALT} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] frame_cnt;
   logic [3:0]       pix;
   logic [10:0]      x_nx, y_nx;
   logic [11:0]      x_inc, x_dec, y_inc, y_dec;

   // 12-bit arithmetic so the clamp sees both overflow past the edge and underflow below 0
   always_comb begin
      x_inc = {1'b0, x_ball} + STEP_W;
      x_dec = {1'b0, x_ball} - STEP_W;
      y_inc = {1'b0, y_ball} + STEP_W;
      y_dec = {1'b0, y_ball} - STEP_W;
      x_nx  = x_ball;
      y_nx  = y_ball;
      if (horizontal) x_nx = (x_inc > X_LIM) ? X_LIM[10:0] : x_inc[10:0];
      else            x_nx = x_dec[11] ? 11'd0 : x_dec[10:0];
      if (!vertical)  y_nx = (y_inc > Y_LIM) ? Y_LIM[10:0] : y_inc[10:0];
      else            y_nx = y_dec[11] ? 11'd0 : y_dec[10:0];
   end

   always_comb begin
      state_nx    = state;
      plot_x      = '0;
      plot_y      = '0;
      plot_colour = '0;
      plot_valid  = 1'b0;
      col_enable  = 1'b0;
      frame_done  = 1'b0;
      case (state)
         S_WAIT: if (enable && frame_cnt == CNT_LAST) state_nx = S_ERASE;
         S_ERASE, S_DRAW: begin
            plot_valid  = 1'b1;
            plot_x      = x_ball + {9'd0, pix[1:0]};
            plot_y      = y_ball + {9'd0, pix[3:2]};
            plot_colour = (state == S_DRAW) ? BALL_COL : BG_COL;
            if (plot_ready && pix == 4'd15) begin
               if (state == S_ERASE) state_nx = S_MOVE;
               else                  state_nx = halted ? S_HALT : S_DONE;
            end
         end
         S_MOVE: state_nx = S_DRAW;
         S_DONE: begin
            frame_done = 1'b1;
            col_enable = 1'b1;
            state_nx   = S_WAIT;
         end
         S_HALT: state_nx = S_HALT;
         default: state_nx = S_WAIT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset_n) begin
         state     <= S_WAIT;
         frame_cnt <= '0;
         pix       <= '0;
         x_ball    <= 11'(X_START);
         y_ball    <= 11'(Y_START);
         halted    <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_WAIT && enable)
            frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + 1'b1;
         // pixel index wraps 15 -> 0 on the last accept, ready for the next box
         if (plot_valid && plot_ready) pix <= pix + 4'd1;
         if (state == S_MOVE) begin
            if (stop) halted <= 1'b1;
            else begin
               x_ball <= x_nx;
               y_ball <= y_nx;
            end
         end
      end
   end

endmodule

// File: tb/tb_ball_mover.sv
// Scoreboard bench for ball_mover: stimulus queues expected pixels and positions,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_ball_mover;
   localparam int FD = 4;

   logic        clock = 1'b0, reset_n = 1'b1, enable = 1'b0;
   logic        horizontal = 1'b0, vertical = 1'b0, stop = 1'b0, plot_ready = 1'b1;
   logic [10:0] x_ball, y_ball, plot_x, plot_y;
   logic [2:0]  plot_colour;
   logic        plot_valid, col_enable, frame_done, halted;

   always #5 clock = ~clock;

   ball_mover #(.FRAME_DIV(FD)) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable),
      .horizontal(horizontal), .vertical(vertical), .stop(stop),
      .x_ball(x_ball), .y_ball(y_ball), .plot_x(plot_x), .plot_y(plot_y),
      .plot_colour(plot_colour), .plot_valid(plot_valid), .plot_ready(plot_ready),
      .col_enable(col_enable), .frame_done(frame_done), .halted(halted)
   );

   typedef struct packed {logic [10:0] x; logic [10:0] y; logic [2:0] c;} pix_t;
   pix_t        pix_q[$];
   logic [21:0] pos_q[$];
   pix_t        e_px, held;
   logic [21:0] e_pos;
   bit          hold_v = 1'b0;
   int          checks = 0, failures = 0;
   int          mx = 156, my = 116, erase_acc = 0, draw_acc = 0, ready_mode = 0;
   int          cyc, cnt;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // ready: always high, or high one cycle in three
   initial begin
      int k = 0;
      forever begin
         @(posedge clock); #1;
         k++;
         plot_ready = (ready_mode == 0) ? 1'b1 : (k % 3 == 0);
      end
   end

   // monitor
   initial forever begin
      @(negedge clock);
      if (hold_v) begin
         chk("hold_x", int'(plot_x), int'(held.x));
         chk("hold_y", int'(plot_y), int'(held.y));
         chk("hold_colour", int'(plot_colour), int'(held.c));
      end
      hold_v = plot_valid && !plot_ready;
      held   = {plot_x, plot_y, plot_colour};
      if (plot_valid && plot_ready) begin
         if (pix_q.size() == 0) chk("unexpected_pixel", 1, 0);
         else begin
            e_px = pix_q.pop_front();
            chk("pixel_x", int'(plot_x), int'(e_px.x));
            chk("pixel_y", int'(plot_y), int'(e_px.y));
            chk("pixel_colour", int'(plot_colour), int'(e_px.c));
         end
         if (plot_colour == 3'b111) draw_acc++; else erase_acc++;
      end
      if (frame_done) begin
         chk("col_enable", int'(col_enable), 1);
         if (pos_q.size() == 0) chk("unexpected_frame_done", 1, 0);
         else begin
            e_pos = pos_q.pop_front();
            chk("pos_x", int'(x_ball), int'(e_pos[21:11]));
            chk("pos_y", int'(y_ball), int'(e_pos[10:0]));
         end
         chk("erase_accepts", erase_acc, 16);
         chk("draw_accepts", draw_acc, 16);
         erase_acc = 0;
         draw_acc  = 0;
      end
   end

   task automatic push_box(input int x, input int y, input logic [2:0] c);
      pix_t t;
      for (int p = 0; p < 16; p++) begin
         t.x = 11'(x + p % 4);
         t.y = 11'(y + p / 4);
         t.c = c;
         pix_q.push_back(t);
      end
   endtask

   task automatic step_model(input bit h, input bit v);
      if (h) mx = (mx + 1 > 316) ? 316 : mx + 1;
      else   mx = (mx - 1 < 0) ? 0 : mx - 1;
      if (!v) my = (my + 1 > 236) ? 236 : my + 1;
      else    my = (my - 1 < 0) ? 0 : my - 1;
   endtask

   // cycles counted from the interval in which reset drops to the one showing frame_done
   task automatic run_frame(input bit h, input bit v, output int c);
      horizontal = h;
      vertical   = v;
      push_box(mx, my, 3'b000);
      step_model(h, v);
      push_box(mx, my, 3'b111);
      pos_q.push_back({11'(mx), 11'(my)});
      c = 1;
      do begin @(negedge clock); c++; end while (!frame_done && c < 3000);
      if (!frame_done) chk("frame_timeout", 0, 1);
   endtask

   initial begin
      // 1: reset and first frame
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_x", int'(x_ball), 156);
      chk("rst_y", int'(y_ball), 116);
      chk("rst_valid", int'(plot_valid), 0);
      chk("rst_plot_x", int'(plot_x), 0);
      chk("rst_plot_y", int'(plot_y), 0);
      chk("rst_colour", int'(plot_colour), 0);
      chk("rst_pulses", int'({col_enable, frame_done, halted}), 0);
      reset_n = 1'b0;
      enable  = 1'b1;
      run_frame(1, 0, cyc);
      chk("first_latency", cyc, 38);
      chk("first_x", int'(x_ball), 157);
      chk("first_y", int'(y_ball), 117);

      // 2: right edge clamp; y also reaches its lower clamp on the way
      while (mx < 315) run_frame(1, 0, cyc);
      chk("x_at_315", int'(x_ball), 315);
      run_frame(1, 0, cyc);
      chk("x_clamp_316", int'(x_ball), 316);
      run_frame(1, 0, cyc);
      chk("x_hold_316", int'(x_ball), 316);
      run_frame(0, 0, cyc);
      chk("x_back_315", int'(x_ball), 315);
      chk("y_clamp_236", int'(y_ball), 236);

      // 3: left/top clamp, no wrap
      while (mx > 0) run_frame(0, 1, cyc);
      run_frame(0, 1, cyc);
      run_frame(0, 1, cyc);
      chk("x_clamp_0", int'(x_ball), 0);
      chk("y_clamp_0", int'(y_ball), 0);

      // 4: throttled ready
      ready_mode = 1;
      run_frame(1, 0, cyc);
      run_frame(1, 0, cyc);
      ready_mode = 0;
      chk("throttle_x", int'(x_ball), 2);
      chk("throttle_y", int'(y_ball), 2);

      // 6: reset while drawing pixel 7
      horizontal = 1'b1;
      vertical   = 1'b0;
      push_box(mx, my, 3'b000);
      step_model(1, 0);
      push_box(mx, my, 3'b111);
      cnt = 0;
      do begin @(negedge clock); cnt++; end
      while (!(plot_valid && plot_ready && plot_colour == 3'b111 &&
               plot_x == 11'(mx + 2) && plot_y == 11'(my + 1)) && cnt < 500);
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      chk("midreset_queue_left", pix_q.size(), 8);
      chk("midreset_valid", int'(plot_valid), 0);
      chk("midreset_x", int'(x_ball), 156);
      chk("midreset_y", int'(y_ball), 116);
      pix_q.delete();
      pos_q.delete();
      erase_acc = 0;
      draw_acc  = 0;
      mx = 156;
      my = 116;
      enable  = 1'b0;
      reset_n = 1'b0;
      cnt = 0;
      repeat (10) begin @(negedge clock); if (plot_valid) cnt++; end
      chk("disabled_no_frame", cnt, 0);
      enable = 1'b1;
      run_frame(1, 0, cyc);
      chk("latency_after_disable", cyc, 38);

      // 5: stop taken in move: one redraw in place, then frozen
      stop       = 1'b1;
      horizontal = 1'b1;
      push_box(mx, my, 3'b000);
      push_box(mx, my, 3'b111);
      cnt = 0;
      do begin @(negedge clock); cnt++; end
      while (!(halted && pix_q.size() == 0 && !plot_valid) && cnt < 500);
      chk("halted", int'(halted), 1);
      chk("halt_x", int'(x_ball), mx);
      chk("halt_y", int'(y_ball), my);
      chk("halt_erase_accepts", erase_acc, 16);
      chk("halt_draw_accepts", draw_acc, 16);
      stop = 1'b0;
      cnt = 0;
      repeat (20 * FD + 40) begin
         @(negedge clock);
         if (plot_valid || frame_done || col_enable) cnt++;
      end
      chk("halt_quiet", cnt, 0);
      chk("halt_frozen_x", int'(x_ball), mx);
      chk("halt_still", int'(halted), 1);

      reset_n = 1'b1;
      @(posedge clock); #1;
      chk("halt_cleared", int'(halted), 0);
      reset_n = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
